// File: rtl/digit_recognizer_pkg.sv
// digit_recognizer_pkg -- shared constants for the digit recognizer.
// Holds the team 5x5 digit font (row 0 in bits [24:20], bit 4 of each row is
// the leftmost pixel), the font geometry and the recognizer state enum.
package digit_recognizer_pkg;
  localparam int DIGIT_COUNT = 10;
  localparam int GLYPH_ROWS  = 5;
  localparam int GLYPH_W     = 5;
  localparam int GLYPH_BITS  = GLYPH_ROWS * GLYPH_W;

  localparam logic [24:0] GLYPH_0 = {5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b11111};
  localparam logic [24:0] GLYPH_1 = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b01110};
  localparam logic [24:0] GLYPH_2 = {5'b11111, 5'b00001, 5'b11111, 5'b10000, 5'b11111};
  localparam logic [24:0] GLYPH_3 = {5'b11111, 5'b00001, 5'b11111, 5'b00001, 5'b11111};
  localparam logic [24:0] GLYPH_4 = {5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001};
  localparam logic [24:0] GLYPH_5 = {5'b11111, 5'b10000, 5'b11111, 5'b00001, 5'b11111};
  localparam logic [24:0] GLYPH_6 = {5'b11111, 5'b10000, 5'b11111, 5'b10001, 5'b11111};
  localparam logic [24:0] GLYPH_7 = {5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
  localparam logic [24:0] GLYPH_8 = {5'b11111, 5'b10001, 5'b11111, 5'b10001, 5'b11111};
  localparam logic [24:0] GLYPH_9 = {5'b11111, 5'b10001, 5'b11111, 5'b00001, 5'b11111};

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SEARCH  = 2'd1,
    S_DONE    = 2'd2
  } state_e;
endpackage

// File: rtl/digit_recognizer_if.sv
// digit_recognizer_if -- row input handshake and result bus.
//   frame_clear : abort current glyph, restart row collection
//   row_valid   : row_bits offered this cycle
//   row_bits    : one glyph row, bit 4 = leftmost pixel
//   row_ready   : recognizer accepts a row this cycle
//   out_valid   : one-cycle result strobe
//   digit_out   : recognized digit 0-9
//   digit_error : last glyph matched no digit
// master = row source / result sink, slave = recognizer.
interface digit_recognizer_if;
  import digit_recognizer_pkg::*;

  logic               frame_clear;
  logic               row_valid;
  logic [GLYPH_W-1:0] row_bits;
  logic               row_ready;
  logic               out_valid;
  logic [3:0]         digit_out;
  logic               digit_error;

  modport master (
    output frame_clear, row_valid, row_bits,
    input  row_ready, out_valid, digit_out, digit_error
  );

  modport slave (
    input  frame_clear, row_valid, row_bits,
    output row_ready, out_valid, digit_out, digit_error
  );
endinterface

// File: rtl/digit_recognizer_rom.sv
// digit_glyph_rom -- combinational font lookup.
//   i_digit : digit index 0-15
//   o_glyph : 25-bit glyph of that digit, 0 for indices 10-15
module digit_glyph_rom
  import digit_recognizer_pkg::*;
(
  input  logic [3:0]            i_digit,
  output logic [GLYPH_BITS-1:0] o_glyph
);
  always_comb begin
    o_glyph = '0;
    case (i_digit)
      4'd0: o_glyph = GLYPH_0;
      4'd1: o_glyph = GLYPH_1;
      4'd2: o_glyph = GLYPH_2;
      4'd3: o_glyph = GLYPH_3;
      4'd4: o_glyph = GLYPH_4;
      4'd5: o_glyph = GLYPH_5;
      4'd6: o_glyph = GLYPH_6;
      4'd7: o_glyph = GLYPH_7;
      4'd8: o_glyph = GLYPH_8;
      4'd9: o_glyph = GLYPH_9;
      default: o_glyph = '0;
    endcase
  end
endmodule

// File: rtl/digit_recognizer.sv
// digit_recognizer -- collects five 5-bit rows into a glyph, then walks the
// font one digit per cycle looking for an exact match.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-high reset
//   bus       : digit_recognizer_if.slave (row handshake + result)
//   err_count : saturating no-match count, only with DIGIT_RECOGNIZER_STATS_EN
// Optional feature macro: DIGIT_RECOGNIZER_STATS_EN.
module digit_recognizer
  import digit_recognizer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  digit_recognizer_if.slave bus
`ifdef DIGIT_RECOGNIZER_STATS_EN
  ,
  output logic [7:0] err_count
`endif
);
  state_e                r_state, w_next_state;
  logic [2:0]            r_row_cnt;
  logic [3:0]            r_idx;
  logic [GLYPH_BITS-1:0] r_glyph;
  logic [3:0]            r_digit;
  logic                  r_err;

  logic [GLYPH_BITS-1:0] w_rom_glyph;
  logic                  w_row_ready, w_accept, w_last_row, w_match, w_last_idx;
  logic [2:0]            w_wr_row;

  digit_glyph_rom u_rom (.i_digit(r_idx), .o_glyph(w_rom_glyph));

  assign w_row_ready = (r_state == S_COLLECT);
  assign w_accept    = bus.row_valid && w_row_ready;
  // A row arriving with frame_clear starts the new glyph as row 0.
  assign w_wr_row    = bus.frame_clear ? 3'd0 : r_row_cnt;
  assign w_last_row  = (w_wr_row == 3'(GLYPH_ROWS - 1));
  assign w_match     = (r_glyph == w_rom_glyph);
  assign w_last_idx  = (r_idx == 4'(DIGIT_COUNT - 1));

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_COLLECT: if (w_accept && w_last_row) w_next_state = S_SEARCH;
      S_SEARCH:  if (w_match || w_last_idx)  w_next_state = S_DONE;
      S_DONE:    w_next_state = S_COLLECT;
      default:   w_next_state = S_COLLECT;
    endcase
    if (bus.frame_clear) w_next_state = S_COLLECT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_COLLECT;
      r_row_cnt <= '0;
      r_idx     <= '0;
      r_glyph   <= '0;
      r_digit   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_accept) r_row_cnt <= w_last_row ? 3'd0 : w_wr_row + 3'd1;
      else if (bus.frame_clear) r_row_cnt <= 3'd0;

      for (int r = 0; r < GLYPH_ROWS; r++)
        if (w_accept && w_wr_row == 3'(r))
          r_glyph[(GLYPH_ROWS-1-r)*GLYPH_W +: GLYPH_W] <= bus.row_bits;

      if (w_accept && w_last_row) r_idx <= '0;
      else if (r_state == S_SEARCH && !w_match && !w_last_idx) r_idx <= r_idx + 4'd1;

      // frame_clear during the search drops the result entirely.
      if (r_state == S_SEARCH && !bus.frame_clear) begin
        if (w_match) begin
          r_digit <= r_idx;
          r_err   <= 1'b0;
        end else if (w_last_idx) begin
          r_digit <= '0;
          r_err   <= 1'b1;
        end
      end
    end
  end

`ifdef DIGIT_RECOGNIZER_STATS_EN
  logic [7:0] r_err_count;
  always_ff @(posedge clk) begin
    if (reset) r_err_count <= '0;
    else if (r_state == S_DONE && r_err && r_err_count != 8'hFF)
      r_err_count <= r_err_count + 8'd1;
  end
  assign err_count = r_err_count;
`endif

  assign bus.row_ready   = w_row_ready;
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.digit_out   = r_digit;
  assign bus.digit_error = r_err;
endmodule

// File: tb/tb_digit_recognizer.sv
module tb_digit_recognizer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  digit_recognizer_if bus();
`ifdef DIGIT_RECOGNIZER_STATS_EN
  logic [7:0] err_count;
`endif

  digit_recognizer dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DIGIT_RECOGNIZER_STATS_EN
    , .err_count(err_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_err    = 0;  // reference no-match counter (saturating)

  // Reference font as rows, row 0 first.
  logic [4:0] font [10][5] = '{
    '{5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b11111},
    '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b01110},
    '{5'b11111, 5'b00001, 5'b11111, 5'b10000, 5'b11111},
    '{5'b11111, 5'b00001, 5'b11111, 5'b00001, 5'b11111},
    '{5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001},
    '{5'b11111, 5'b10000, 5'b11111, 5'b00001, 5'b11111},
    '{5'b11111, 5'b10000, 5'b11111, 5'b10001, 5'b11111},
    '{5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001},
    '{5'b11111, 5'b10001, 5'b11111, 5'b10001, 5'b11111},
    '{5'b11111, 5'b10001, 5'b11111, 5'b00001, 5'b11111}
  };

  typedef struct {
    logic [24:0] glyph;
    logic [3:0]  exp_d;
    logic        exp_e;
    int          exp_lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [24:0] font_glyph(input int d);
    logic [24:0] g = '0;
    for (int r = 0; r < 5; r++) g[(4-r)*5 +: 5] = font[d][r];
    return g;
  endfunction

  // Returns the matching digit, or 10 when no font entry equals the glyph.
  function automatic int ref_decode(input logic [24:0] g);
    for (int d = 0; d < 10; d++) begin
      bit hit = 1'b1;
      for (int r = 0; r < 5; r++)
        if (g[(4-r)*5 +: 5] != font[d][r]) hit = 1'b0;
      if (hit) return d;
    end
    return 10;
  endfunction

  // Feeds rows start_row..4 of g, waits for the result and checks it.
  task automatic do_glyph(input logic [24:0] g, input int start_row, input int max_gap,
                          input bit hold, input logic [3:0] exp_d, input logic exp_e,
                          input int exp_lat, input string tag);
    int cnt, rdy_low, gap;
    for (int r = start_row; r < 5; r++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      bus.row_valid = 1'b0;
      repeat (gap) tick();
      bus.row_valid = 1'b1;
      bus.row_bits  = g[(4-r)*5 +: 5];
      chk({tag, ".row_ready_collect"}, 32'(bus.row_ready), 32'd1);
      tick();
    end
    bus.row_valid = hold;
    cnt = 0;
    rdy_low = 0;
    while (bus.out_valid !== 1'b1 && cnt < 40) begin
      if (bus.row_ready === 1'b0) rdy_low++;
      if (hold) bus.row_bits = 5'($urandom);
      tick();
      cnt++;
    end
    chk({tag, ".latency"}, 32'(cnt), 32'(exp_lat));
    chk({tag, ".search_rdy_low"}, 32'(rdy_low), 32'(exp_lat));
    chk({tag, ".digit"}, 32'(bus.digit_out), 32'(exp_d));
    chk({tag, ".error"}, 32'(bus.digit_error), 32'(exp_e));
    chk({tag, ".rdy_done"}, 32'(bus.row_ready), 32'd0);
    bus.row_valid = 1'b0;
    tick();
    if (exp_e && m_err < 255) m_err++;
    chk({tag, ".one_shot"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".digit_hold"}, 32'(bus.digit_out), 32'(exp_d));
`ifdef DIGIT_RECOGNIZER_STATS_EN
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_err));
`endif
  endtask

  task automatic do_ref(input logic [24:0] g, input int max_gap, input bit hold, input string tag);
    int d = ref_decode(g);
    do_glyph(g, 0, max_gap, hold, (d == 10) ? 4'd0 : 4'(d), d == 10,
             (d == 10) ? 10 : d + 1, tag);
  endtask

  task automatic watch_no_valid(input int n, input string tag);
    int seen = 0;
    repeat (n) begin
      if (bus.out_valid === 1'b1) seen++;
      tick();
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [24:0] g;
    bus.frame_clear = 1'b0;
    bus.row_valid   = 1'b0;
    bus.row_bits    = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst.row_ready", 32'(bus.row_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.digit", 32'(bus.digit_out), 32'd0);
    chk("rst.error", 32'(bus.digit_error), 32'd0);
`ifdef DIGIT_RECOGNIZER_STATS_EN
    chk("rst.err_count", 32'(err_count), 32'd0);
`endif

    // Directed vectors with hand-derived expectations.
    vecs[0] = '{{5'b11111,5'b00001,5'b11111,5'b00001,5'b11111}, 4'd3, 1'b0, 4};
    vecs[1] = '{25'd0, 4'd0, 1'b1, 10};
    vecs[2] = '{{5'b11111,5'b10001,5'b10001,5'b10001,5'b11111}, 4'd0, 1'b0, 1};
    vecs[3] = '{{5'b11111,5'b10001,5'b11111,5'b00001,5'b11111}, 4'd9, 1'b0, 10};
    vecs[4] = '{{5'b00100,5'b01100,5'b00100,5'b00100,5'b01110}, 4'd1, 1'b0, 2};
    vecs[5] = '{{5'b11111,5'b10000,5'b11111,5'b00001,5'b11111}, 4'd5, 1'b0, 6};
    vecs[6] = '{{5'b11111,5'b10000,5'b11111,5'b10001,5'b11110}, 4'd0, 1'b1, 10};
    vecs[7] = '{{5'b11111,5'b11111,5'b11111,5'b11111,5'b11111}, 4'd0, 1'b1, 10};
    vecs[8] = '{{5'b10001,5'b10001,5'b11111,5'b00001,5'b00001}, 4'd4, 1'b0, 5};
    vecs[9] = '{{5'b11111,5'b00001,5'b11111,5'b10000,5'b11111}, 4'd2, 1'b0, 3};
    for (int i = 0; i < 10; i++)
      do_glyph(vecs[i].glyph, 0, 0, 1'b0, vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_lat,
               $sformatf("vec%0d", i));

    // Two stray rows, then frame_clear, then a clean 7.
    bus.row_valid = 1'b1; bus.row_bits = 5'b10101; tick();
    bus.row_bits = 5'b01010; tick();
    bus.row_valid = 1'b0; bus.frame_clear = 1'b1; tick();
    bus.frame_clear = 1'b0;
    chk("clr.no_valid", 32'(bus.out_valid), 32'd0);
    do_glyph({5'b11111,5'b00001,5'b00001,5'b00001,5'b00001}, 0, 0, 1'b0, 4'd7, 1'b0, 8, "clr7");

    // frame_clear coinciding with an accepted row: that row becomes row 0.
    bus.row_valid = 1'b1;
    repeat (3) begin bus.row_bits = 5'($urandom); tick(); end
    g = font_glyph(2);
    bus.frame_clear = 1'b1; bus.row_bits = g[24:20]; tick();
    bus.frame_clear = 1'b0;
    do_glyph(g, 1, 0, 1'b0, 4'd2, 1'b0, 3, "clrrow");

    // frame_clear mid-search drops the result.
    bus.row_valid = 1'b1; bus.row_bits = 5'b0;
    repeat (5) tick();
    bus.row_valid = 1'b0;
    tick(); tick();
    bus.frame_clear = 1'b1; tick();
    bus.frame_clear = 1'b0;
    chk("midclr.row_ready", 32'(bus.row_ready), 32'd1);
    watch_no_valid(12, "midclr.no_valid");
    chk("midclr.digit_kept", 32'(bus.digit_out), 32'd2);

    // 8 with row_valid held through the search, then 3 proves no stray capture.
    do_glyph(font_glyph(8), 0, 0, 1'b1, 4'd8, 1'b0, 9, "hold8");
    do_glyph(font_glyph(3), 0, 0, 1'b0, 4'd3, 1'b0, 4, "after8");

    // Randomized glyphs against the reference decoder.
    for (int i = 0; i < 40; i++) begin
      int kind = int'($urandom_range(0, 2));
      g = font_glyph(int'($urandom_range(0, 9)));
      if (kind == 1) g[$urandom_range(0, 24)] ^= 1'b1;
      if (kind == 2) g = 25'($urandom);
      do_ref(g, 2, 1'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset in the third search cycle suppresses the pending result.
    do_glyph(font_glyph(9), 0, 0, 1'b0, 4'd9, 1'b0, 10, "pre_rst");
    bus.row_valid = 1'b1; bus.row_bits = 5'b0;
    repeat (5) tick();
    bus.row_valid = 1'b0;
    tick(); tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    m_err = 0;
    chk("srst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("srst.digit", 32'(bus.digit_out), 32'd0);
    chk("srst.error", 32'(bus.digit_error), 32'd0);
    chk("srst.row_ready", 32'(bus.row_ready), 32'd1);
`ifdef DIGIT_RECOGNIZER_STATS_EN
    chk("srst.err_count", 32'(err_count), 32'd0);
`endif
    watch_no_valid(12, "srst.no_valid");

`ifdef DIGIT_RECOGNIZER_STATS_EN
    for (int i = 0; i < 3; i++) do_glyph(25'd0, 0, 0, 1'b0, 4'd0, 1'b1, 10, "st_miss");
    do_glyph(font_glyph(1), 0, 0, 1'b0, 4'd1, 1'b0, 2, "st_hit");
    chk("stats.three", 32'(err_count), 32'd3);
    for (int i = 0; i < 300; i++) do_glyph(25'd0, 0, 0, 1'b0, 4'd0, 1'b1, 10, "st_sat");
    chk("stats.sat", 32'(err_count), 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/digit_recognizer.md
DIGIT_RECOGNIZER -- requirements
Module: digit_recognizer

Interface
REQ-001 The block SHALL have these ports: clk, in, 1, system clock; all state SHALL change only on its rising edge.
REQ-002 The block SHALL have these ports: reset, in, 1, synchronous active-high reset.
REQ-003 The block SHALL have these ports: frame_clear, in, 1, abort the current glyph and restart row collection.
REQ-004 The block SHALL have these ports: row_valid, in, 1, row_bits is offered this cycle.
REQ-005 The block SHALL have these ports: row_bits, in, 5, one glyph row; bit 4 = leftmost pixel.
REQ-006 The block SHALL have these ports: row_ready, out, 1, the block accepts a row this cycle.
REQ-007 The block SHALL have these ports: out_valid, out, 1, one-cycle result strobe.
REQ-008 The block SHALL have these ports: digit_out, out, 4, recognized digit 0-9.
REQ-009 The block SHALL have these ports: digit_error, out, 1, the last glyph matched no digit.
REQ-010 The block SHALL have these ports: err_count, out, 8, saturating no-match count; present only with DIGIT_RECOGNIZER_STATS_EN.

Function
REQ-011 The block SHALL perform the inverse of the 5x5 digit font, turning five rows back into a digit.
REQ-012 The state machine SHALL have three states: COLLECT, SEARCH and DONE.
REQ-013 row_ready SHALL be 1 only in COLLECT.
REQ-014 A row SHALL be accepted when row_valid and row_ready are both 1.
REQ-015 An accepted row SHALL be stored at the index given by a 3-bit row counter (0-4), and the counter SHALL then increment.
REQ-016 Row 0 SHALL occupy glyph bits [24:20] and row 4 SHALL occupy bits [4:0].
REQ-017 Accepting row 4 SHALL reset the row counter to 0, set the search index to 0 and move to SEARCH.
REQ-018 In each SEARCH cycle, the captured 25-bit glyph SHALL be compared for exact equality with glyph(index).
- Equal: the block SHALL set digit_out to the index, clear digit_error and move to DONE.
- Not equal and index < 9: the index SHALL increment.
- Not equal and index = 9: the block SHALL set digit_error to 1, set digit_out to 0 and move to DONE.
REQ-019 DONE SHALL last exactly one cycle with out_valid = 1, then move to COLLECT.
REQ-020 Latency: out_valid SHALL be high in the cycle following edge E+d+1, where E is the edge that accepts row 4 and d is the matched index (d = 9 for no match).
REQ-021 digit_out and digit_error SHALL hold their values until the next DONE.
REQ-022 frame_clear in any state SHALL go to COLLECT and clear the row counter, with no out_valid.
REQ-023 If frame_clear and an accepted row coincide, the row SHALL be stored as row 0 and the counter SHALL become 1.
REQ-024 row_valid in SEARCH or DONE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-025 On reset, the state SHALL go to COLLECT and the row counter and search index SHALL be 0.
REQ-026 On reset, out_valid, digit_out, digit_error and err_count SHALL be 0, and the glyph buffer SHALL be 0.
REQ-027 Reset SHALL take priority over frame_clear and row_valid.
REQ-028 Reset mid-SEARCH SHALL suppress the pending result.

Configuration
REQ-029 With DIGIT_RECOGNIZER_STATS_EN defined, err_count SHALL increment on every DONE that has digit_error = 1, saturating at 255.
REQ-030 Without DIGIT_RECOGNIZER_STATS_EN, the err_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 The shared package SHALL hold: the ten 25-bit glyph constants of the team digit font, DIGIT_COUNT = 10, GLYPH_ROWS = 5, GLYPH_W = 5, and the state enum.
REQ-032 Glyph lookup SHALL be a sub-module, digit_glyph_rom (4-bit digit in, 25-bit glyph out, combinational, 0 for digits 10-15).

Verification
REQ-033 Scenario 1: rows 11111,00001,11111,00001,11111 on consecutive cycles -> out_valid one cycle, 4 edges after E; digit_out = 3; digit_error = 0.
REQ-034 Scenario 2: five rows of 00000 -> out_valid 10 edges after E; digit_error = 1; digit_out = 0.
REQ-035 Scenario 3: two arbitrary rows, then frame_clear, then 7's rows (11111,00001,00001,00001,00001) -> digit_out = 7, with no prior out_valid.
REQ-036 Scenario 4: 8's rows (11111,10001,11111,10001,11111) with row_valid held high through the search -> row_ready = 0 for 9 cycles, digit_out = 8, and the extra rows SHALL NOT be captured.
REQ-037 Scenario 5: reset asserted in the 3rd SEARCH cycle -> no out_valid, all outputs 0, row_ready = 1 on the next cycle.
REQ-038 Scenario 6: with DIGIT_RECOGNIZER_STATS_EN, 3 no-match glyphs then 1 valid glyph -> err_count = 3; 300 no-match glyphs -> err_count = 255.
